// File: rtl/stream_mux_rr.sv
// ---------------------------------------------------------------------------
// stream_mux_rr
//   Registered M-to-1 stream multiplexer with round-robin arbitration.
//   Several producers share one consumer. Arbitration is internal, so no
//   external select is needed. The single-entry output register refills in the
//   same cycle it is popped, which gives one beat per cycle with out_ready held
//   high.
//
// Parameters
//   N   data width per channel
//   M   number of input channels
//   SW  width of the channel index (derived)
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_data    M*N  channel i at bits [i*N +: N]
//   in_valid   M    channel i presents a beat
//   in_ready   M    one-hot (or zero): beat on that channel is accepted now
//   out_data   N    registered output beat
//   out_valid  1    out_data holds a beat
//   out_ready  1    consumer takes the beat this cycle
//   out_sel    SW   source channel of the current out_data
//
// Optional feature: macro STREAM_MUX_PKT_LOCK_EN
//   Adds in_last (M), out_last (1) and dbg_locked (1, lock FSM state).
//   Once a channel is granted a beat without last, it keeps the grant until
//   its last beat is accepted, so packets are never interleaved.
//
// Handshake: a beat moves on a port in any cycle where valid and ready are
// both high; valid must not wait for ready, while in_ready here depends
// combinationally on out_ready and on in_valid.
// ---------------------------------------------------------------------------
module stream_mux_rr #(
    parameter int  N  = 8,
    parameter int  M  = 4,
    localparam int SW = (M > 1) ? $clog2(M) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [M*N-1:0] in_data,
    input  logic [M-1:0]   in_valid,
    output logic [M-1:0]   in_ready,
`ifdef STREAM_MUX_PKT_LOCK_EN
    input  logic [M-1:0]   in_last,
    output logic           out_last,
    output logic           dbg_locked,
`endif
    output logic [N-1:0]   out_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [SW-1:0]  out_sel
);

    logic [SW-1:0] ptr_q, ptr_d;
    logic [N-1:0]  data_q;
    logic          valid_q;
    logic [SW-1:0] sel_q;

    logic          load_en;
    logic          accept;
    logic          has_grant;
    logic [SW-1:0] grant;
    logic          rr_found;
    logic [SW-1:0] rr_grant;

    // Round-robin search: first valid channel at or after ptr, wrapping.
    always_comb begin
        int j;
        rr_found = 1'b0;
        rr_grant = '0;
        j        = 0;
        for (int k = 0; k < M; k++) begin
            j = int'(ptr_q) + k;
            if (j >= M) begin
                j = j - M;
            end
            if (!rr_found && in_valid[SW'(j)]) begin
                rr_found = 1'b1;
                rr_grant = SW'(j);
            end
        end
    end

`ifdef STREAM_MUX_PKT_LOCK_EN
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } lock_state_t;

    lock_state_t   state_q, state_d;
    logic [SW-1:0] lock_ch_q, lock_ch_d;
    logic          last_q;

    // While locked, only the owning channel may be granted, even when idle.
    always_comb begin
        grant     = rr_grant;
        has_grant = rr_found;
        if (state_q == LOCKED) begin
            grant     = lock_ch_q;
            has_grant = in_valid[lock_ch_q];
        end
    end

    always_comb begin
        state_d   = state_q;
        lock_ch_d = lock_ch_q;
        if (accept) begin
            case (state_q)
                IDLE: begin
                    if (!in_last[grant]) begin
                        state_d   = LOCKED;
                        lock_ch_d = grant;
                    end
                end
                LOCKED: begin
                    if (in_last[grant]) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            lock_ch_q <= '0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lock_ch_q <= lock_ch_d;
            if (accept) begin
                last_q <= in_last[grant];
            end
        end
    end

    assign out_last   = last_q;
    assign dbg_locked = (state_q == LOCKED);
`else
    always_comb begin
        grant     = rr_grant;
        has_grant = rr_found;
    end
`endif

    // The output slot can take a new beat when empty or being popped now.
    assign load_en = !valid_q || out_ready;
    assign accept  = rst_n && has_grant && load_en;

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < M; i++) begin
            in_ready[i] = accept && (grant == SW'(i));
        end
    end

    // Pointer moves just past the winner; with M=1 this is always 0.
    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = (grant == SW'(M - 1)) ? '0 : grant + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            sel_q   <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (accept) begin
                data_q  <= in_data[grant*N +: N];
                sel_q   <= grant;
                valid_q <= 1'b1;
            end else if (out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_sel   = sel_q;

endmodule
